// File: rtl/force_pipeline_arbiter_pkg.sv
// Shared constants and types for the force pipeline arbiter slice.
// The tag records which requester owns each operation in flight through force_pipeline.
package force_pipeline_arbiter_pkg;

    localparam int unsigned AXIS_TDATA_WIDTH   = 32;
    localparam int unsigned FP_LATENCY_DEFAULT = 12;
    // Tag index is sized for up to 16 requesters.
    localparam int unsigned TAG_IDX_W          = 4;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } fp_tag_t;

endpackage

// File: rtl/force_pipeline_arbiter_if.sv
// Requester, force_pipeline and response signals of the arbiter.
// The master modport is the arbiter side; slave is the surrounding logic.
interface force_pipeline_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned DW = force_pipeline_arbiter_pkg::AXIS_TDATA_WIDTH;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ*32-1:0] req_scale;
    logic [DW-1:0]         fp_a_tdata;
    logic                  fp_a_tvalid;
    logic [31:0]           fp_b_tdata;
    logic                  fp_b_tvalid;
    logic [DW-1:0]         fp_result_tdata;
    logic                  fp_result_tvalid;
    logic [DW-1:0]         rsp_data;
    logic [NUM_REQ-1:0]    rsp_valid;

    modport master (
        input  req_valid, req_data, req_scale, fp_result_tdata, fp_result_tvalid,
        output req_ready, fp_a_tdata, fp_a_tvalid, fp_b_tdata, fp_b_tvalid, rsp_data, rsp_valid
    );

    modport slave (
        output req_valid, req_data, req_scale, fp_result_tdata, fp_result_tvalid,
        input  req_ready, fp_a_tdata, fp_a_tvalid, fp_b_tdata, fp_b_tvalid, rsp_data, rsp_valid
    );

endinterface

// File: rtl/force_pipeline_arbiter_rr_arbiter.sv
// Combinational round-robin grant; the pointer moves to the granted index on every grant.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Search starts strictly after the last grant, so a held request is never skipped.
    always_comb begin
        grant     = '0;
        grant_idx = ptr_q;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((32'(ptr_q) + off) % NUM_REQ);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (found) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/force_pipeline_arbiter.sv
// Shares one force_pipeline among NUM_REQ requesters and routes each result back
// to its owner through a tag pipeline that tracks the fixed pipeline latency.
module force_pipeline_arbiter
    import force_pipeline_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FP_LATENCY = FP_LATENCY_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              arb_en,
    force_pipeline_arbiter_if.master          bus,
    output logic [$clog2(FP_LATENCY+2)-1:0]   inflight,
    output logic                              tag_error
);

    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W   = $clog2(FP_LATENCY + 2);
    localparam int unsigned DRAIN_W = $clog2(FP_LATENCY + 1);
    localparam int unsigned DW      = AXIS_TDATA_WIDTH;

    logic [DRAIN_W-1:0] drain_q;
    logic               grant_en;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept;
    logic [DW-1:0]      sel_a;
    logic [31:0]        sel_b;

    logic [DW-1:0]      fp_a_q;
    logic [31:0]        fp_b_q;
    logic               fp_valid_q;
    logic [IDX_W-1:0]   issue_idx_q;

    fp_tag_t            tag_q [FP_LATENCY];
    fp_tag_t            head;
    logic               hit;
    logic               mismatch;

    logic [DW-1:0]      rsp_data_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [CNT_W-1:0]   inflight_q;
    logic               tag_error_q;

    // Grants stay blocked until results issued before reset have flushed out.
    assign grant_en = rst_n & arb_en & (drain_q == '0);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (grant_en),
        .req       (bus.req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept        = |grant;
    assign bus.req_ready = grant;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = bus.req_data[i*DW +: DW];
                sel_b = bus.req_scale[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_q <= DRAIN_W'(FP_LATENCY);
        end else if (drain_q != '0) begin
            drain_q <= drain_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fp_a_q      <= '0;
            fp_b_q      <= '0;
            fp_valid_q  <= 1'b0;
            issue_idx_q <= '0;
        end else begin
            fp_valid_q <= accept;
            if (accept) begin
                fp_a_q      <= sel_a;
                fp_b_q      <= sel_b;
                issue_idx_q <= grant_idx;
            end
        end
    end

    assign bus.fp_a_tdata  = fp_a_q;
    assign bus.fp_b_tdata  = fp_b_q;
    assign bus.fp_a_tvalid = fp_valid_q;
    assign bus.fp_b_tvalid = fp_valid_q;

    // Pushed on the issue cycle so the head lines up with fp_result_tvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FP_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: fp_valid_q, idx: TAG_IDX_W'(issue_idx_q)};
            for (int i = 1; i < FP_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign head     = tag_q[FP_LATENCY-1];
    assign hit      = head.valid & bus.fp_result_tvalid;
    assign mismatch = (head.valid ^ bus.fp_result_tvalid) & (drain_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            inflight_q  <= '0;
            tag_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (hit) begin
                rsp_data_q  <= bus.fp_result_tdata;
                rsp_valid_q <= NUM_REQ'(1) << head.idx;
            end
            unique case ({accept, hit})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
            if (mismatch) begin
                tag_error_q <= 1'b1;
            end
        end
    end

    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign inflight      = inflight_q;
    assign tag_error     = tag_error_q;

endmodule

// File: tb/tb_force_pipeline_arbiter.sv
// Bench for force_pipeline_arbiter: a behavioural force_pipeline (FP32 multiply with fixed
// latency) plus a scoreboard model of grants, responses, inflight and tag_error.
module tb_force_pipeline_arbiter;
    import force_pipeline_arbiter_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned L = 12;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       arb_en = 1'b0;
    logic       inject = 1'b0;
    logic [3:0] inflight;
    logic       tag_error;

    force_pipeline_arbiter_if #(.NUM_REQ(N)) bus ();

    force_pipeline_arbiter #(
        .NUM_REQ    (N),
        .FP_LATENCY (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .bus       (bus),
        .inflight  (inflight),
        .tag_error (tag_error)
    );

    always #5 clk = ~clk;

    function automatic real fp32_to_real(input logic [31:0] f);
        logic [63:0] d;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          e;
        p = $realtobits(fp32_to_real(a) * fp32_to_real(b));
        e = int'(p[62:52]) - 1023 + 127;
        return {p[63], e[7:0], p[51:29]};
    endfunction

    // Behavioural force_pipeline: no reset, so stale results can emerge after a reset.
    logic        pv [L] = '{default: 1'b0};
    logic [31:0] pd [L] = '{default: 32'h0};
    always @(posedge clk) begin
        pv[0] <= bus.fp_a_tvalid;
        pd[0] <= fp32_mul(bus.fp_a_tdata, bus.fp_b_tdata);
        for (int k = 1; k < L; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end
    assign bus.fp_result_tvalid = pv[L-1] | inject;
    assign bus.fp_result_tdata  = pd[L-1];

    typedef struct {
        int          t;
        int          idx;
        logic [31:0] res;
    } op_t;

    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic [3:0] ready;
    } vec_t;

    op_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          edges = 0;
    int          mptr = N - 1;
    logic        exp_err = 1'b0;
    logic        prev_acc = 1'b0;
    logic [31:0] prev_a, prev_b;
    logic        rec_en = 1'b0;
    int          gq[$];
    int          rq[$];
    int          rc[$];
    int          peak = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            bus.req_data[i*32 +: 32]  = rnd_fp();
            bus.req_scale[i*32 +: 32] = rnd_fp();
        end
    endtask

    task automatic sample();
        logic [N-1:0] eg;
        logic [N-1:0] erv;
        logic [31:0]  erd;
        int           gi;
        int           exp_inf;
        @(negedge clk);
        eg = '0;
        gi = -1;
        if (rst_n && arb_en && edges >= L) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mptr + k) % N;
                if (gi < 0 && bus.req_valid[c]) gi = c;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(eg));
        chk("fp_a_tvalid", 32'(bus.fp_a_tvalid), 32'(prev_acc && rst_n));
        chk("fp_b_tvalid", 32'(bus.fp_b_tvalid), 32'(prev_acc && rst_n));
        if (prev_acc && rst_n) begin
            chk("fp_a_tdata", bus.fp_a_tdata, prev_a);
            chk("fp_b_tdata", bus.fp_b_tdata, prev_b);
        end
        erv = '0;
        erd = '0;
        exp_inf = 0;
        foreach (sb[j]) begin
            if (sb[j].t + L + 2 == cyc) begin
                erv[sb[j].idx] = 1'b1;
                erd = sb[j].res;
            end
            if (sb[j].t < cyc && cyc <= sb[j].t + L + 1) exp_inf++;
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(erv));
        if (erv != '0) chk("rsp_data", bus.rsp_data, erd);
        chk("inflight", 32'(inflight), 32'(exp_inf));
        chk("tag_error", 32'(tag_error), 32'(exp_err));
        if (!rst_n) begin
            chk("rst_fp_a_tdata", bus.fp_a_tdata, 32'h0);
            chk("rst_fp_b_tdata", bus.fp_b_tdata, 32'h0);
            chk("rst_rsp_data", bus.rsp_data, 32'h0);
        end
        if (rec_en) begin
            if (bus.req_ready != '0) gq.push_back(oh2i(bus.req_ready));
            if (bus.rsp_valid != '0) begin
                rq.push_back(oh2i(bus.rsp_valid));
                rc.push_back(cyc);
            end
            if (int'(inflight) > peak) peak = int'(inflight);
        end
        prev_acc = (gi >= 0);
        if (gi >= 0) begin
            prev_a = bus.req_data[gi*32 +: 32];
            prev_b = bus.req_scale[gi*32 +: 32];
            sb.push_back('{t: cyc, idx: gi, res: fp32_mul(prev_a, prev_b)});
            mptr = gi;
        end
        while (sb.size() > 0 && sb[0].t + L + 2 <= cyc) void'(sb.pop_front());
    endtask

    task automatic advance();
        @(posedge clk);
        cyc++;
        if (rst_n) edges++;
        else edges = 0;
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        sb.delete();
        exp_err  = 1'b0;
        mptr     = N - 1;
        prev_acc = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 3 * L && edges < L; k++) tick();
    endtask

    task automatic start_rec();
        gq.delete();
        rq.delete();
        rc.delete();
        peak   = 0;
        rec_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [12];
        int   t_acc;
        int   got_cyc;
        int   got_own;
        int   n_rel;
        logic [31:0] got_data;

        tbl[0]  = '{1'b1, 4'b1111, 4'b0001};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0010};
        tbl[2]  = '{1'b1, 4'b0101, 4'b0100};
        tbl[3]  = '{1'b1, 4'b0101, 4'b0001};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0000};
        tbl[5]  = '{1'b1, 4'b1000, 4'b1000};
        tbl[6]  = '{1'b1, 4'b1000, 4'b1000};
        tbl[7]  = '{1'b1, 4'b0000, 4'b0000};
        tbl[8]  = '{1'b1, 4'b0011, 4'b0001};
        tbl[9]  = '{1'b1, 4'b1010, 4'b0010};
        tbl[10] = '{1'b1, 4'b0110, 4'b0100};
        tbl[11] = '{1'b1, 4'b1111, 4'b1000};

        bus.req_valid = '0;
        rand_data();
        #2;
        do_reset(3);

        // Single operation with known operands: 1.0 * 2.0.
        arb_en = 1'b1;
        wait_drain();
        bus.req_valid = 4'b0001;
        bus.req_data[31:0]  = 32'h3f800000;
        bus.req_scale[31:0] = 32'h40000000;
        t_acc = cyc;
        tick();
        bus.req_valid = '0;
        got_cyc  = -1;
        got_own  = 0;
        got_data = '0;
        for (int k = 0; k < 3 * L; k++) begin
            sample();
            if (got_cyc < 0 && bus.rsp_valid != '0) begin
                got_cyc  = cyc;
                got_own  = int'(bus.rsp_valid);
                got_data = bus.rsp_data;
            end
            advance();
        end
        chk("single_latency", 32'(got_cyc - t_acc), 32'(L + 2));
        chk("single_owner", 32'(got_own), 32'h1);
        chk("single_data", got_data, 32'h40000000);

        // All four requesters valid for eight grants straight out of reset.
        bus.req_valid = 4'b1111;
        do_reset(2);
        start_rec();
        wait_drain();
        repeat (8) begin
            rand_data();
            tick();
        end
        bus.req_valid = '0;
        repeat (L + 6) tick();
        rec_en = 1'b0;
        chk("rr8_grants", 32'(gq.size()), 32'd8);
        chk("rr8_rsps", 32'(rq.size()), 32'd8);
        for (int i = 0; i < 8 && i < gq.size() && i < rq.size(); i++) begin
            chk("rr8_grant_order", 32'(gq[i]), 32'(i % 4));
            chk("rr8_rsp_order", 32'(rq[i]), 32'(i % 4));
            chk("rr8_rsp_contig", 32'(rc[i] - rc[0]), 32'(i));
        end
        chk("rr8_peak", 32'(peak), 32'd8);

        // Continuous full throughput reaches the steady-state inflight count.
        start_rec();
        bus.req_valid = 4'b1111;
        repeat (24) begin
            rand_data();
            tick();
        end
        bus.req_valid = '0;
        repeat (L + 6) tick();
        rec_en = 1'b0;
        chk("full_peak", 32'(peak), 32'(L + 1));
        chk("full_rsps", 32'(rq.size()), 32'd24);

        // Table of grant patterns from a fresh pointer.
        do_reset(2);
        wait_drain();
        for (int i = 0; i < 12; i++) begin
            arb_en        = tbl[i].en;
            bus.req_valid = tbl[i].valid;
            rand_data();
            sample();
            chk("tbl_ready", 32'(bus.req_ready), 32'(tbl[i].ready));
            advance();
        end
        arb_en        = 1'b1;
        bus.req_valid = '0;
        repeat (L + 4) tick();

        // Disabling arb_en blocks grants while in-flight results still return.
        start_rec();
        bus.req_valid = 4'b1111;
        repeat (3) tick();
        arb_en = 1'b0;
        repeat (L + 6) begin
            sample();
            chk("dis_ready", 32'(bus.req_ready), 32'h0);
            advance();
        end
        rec_en = 1'b0;
        chk("dis_rsps", 32'(rq.size()), 32'd3);
        chk("dis_inflight", 32'(inflight), 32'h0);
        arb_en        = 1'b1;
        bus.req_valid = '0;

        // Randomised traffic against the scoreboard.
        for (int i = 0; i < 800; i++) begin
            arb_en        = ($urandom_range(7, 0) != 0);
            bus.req_valid = 4'($urandom);
            rand_data();
            tick();
        end
        arb_en        = 1'b1;
        bus.req_valid = '0;
        repeat (L + 4) tick();

        // Reset with five operations in flight.
        bus.req_valid = 4'b1111;
        repeat (5) begin
            rand_data();
            tick();
        end
        bus.req_valid = '0;
        repeat (2) tick();
        chk("pre_rst_inflight", 32'(inflight), 32'd5);
        bus.req_valid = 4'b1111;
        do_reset(2);
        start_rec();
        n_rel = -1;
        for (int k = 0; k < 3 * L && n_rel < 0; k++) begin
            sample();
            if (bus.req_ready != '0) n_rel = k;
            advance();
        end
        rec_en = 1'b0;
        chk("rst_first_grant", 32'(n_rel), 32'(L));
        chk("rst_no_rsp", 32'(rq.size()), 32'h0);
        chk("rst_no_err", 32'(tag_error), 32'h0);
        bus.req_valid = '0;
        repeat (L + 4) tick();

        // Stray result with an empty tag head.
        inject = 1'b1;
        tick();
        inject  = 1'b0;
        exp_err = 1'b1;
        repeat (6) begin
            sample();
            chk("inj_err", 32'(tag_error), 32'h1);
            chk("inj_no_rsp", 32'(bus.rsp_valid), 32'h0);
            advance();
        end
        do_reset(2);
        repeat (3) tick();
        chk("err_cleared", 32'(tag_error), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
